// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel window controller: pixel width, default
// frame geometry and the controller FSM state encoding.
package sobel_pkg;

    localparam int PIX_W     = 8;
    localparam int H_ACT_DEF = 640;
    localparam int V_ACT_DEF = 480;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/sobel_line_buf.sv
// One video line of pixel storage: a write port plus a synchronous read port
// that returns the pre-write contents when both ports hit the same address.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int DEPTH = H_ACT_DEF,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [PIX_W-1:0] rd_data
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[IW-1:0]] <= wr_data;
        end
    end

    // The read register doubles as a window column, so it is cleared on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr[IW-1:0]];
        end
    end

endmodule

// File: rtl/sobel_win_ctrl.sv
// Raster window builder in front of the Sobel detector: 3x3 window, interior
// valid flag and end-of-frame pulse. Optional frame counter: SOBEL_FRAME_CNT_EN.
module sobel_win_ctrl
    import sobel_pkg::*;
#(
    parameter int H_ACT = H_ACT_DEF,
    parameter int V_ACT = V_ACT_DEF,
    parameter int CW    = 10,
    parameter int RW    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vsync,
    input  logic             gray_valid,
    input  logic [PIX_W-1:0] gray_data,
    output logic [PIX_W-1:0] p11,
    output logic [PIX_W-1:0] p12,
    output logic [PIX_W-1:0] p13,
    output logic [PIX_W-1:0] p21,
    output logic [PIX_W-1:0] p22,
    output logic [PIX_W-1:0] p23,
    output logic [PIX_W-1:0] p31,
    output logic [PIX_W-1:0] p32,
    output logic [PIX_W-1:0] p33,
    output logic             data_en,
    output logic             frame_done,
    output logic             busy
`ifdef SOBEL_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    state_t        state_q, state_d;
    logic          vsync_q, vsync_rise;
    logic          accept, col_last, last_px, acc_d;
    logic [CW-1:0] col_q, acc_col, col_d;
    logic [RW-1:0] row_q, acc_row;

    // A restart edge overrides the stored position so its pixel lands at (0,0).
    assign vsync_rise = vsync & ~vsync_q;
    assign accept     = gray_valid & (vsync_rise | (state_q == ST_ACTIVE));
    assign acc_col    = vsync_rise ? '0 : col_q;
    assign acc_row    = vsync_rise ? '0 : row_q;
    assign col_last   = (acc_col == CW'(H_ACT - 1));
    assign last_px    = accept & col_last & (acc_row == RW'(V_ACT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (vsync_rise) state_d = ST_ACTIVE;
            ST_ACTIVE: begin
                if (vsync_rise)   state_d = ST_ACTIVE;
                else if (last_px) state_d = ST_DONE;
            end
            ST_DONE:   if (vsync_rise) state_d = ST_ACTIVE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            acc_d   <= 1'b0;
            col_d   <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            vsync_q <= vsync;
            acc_d   <= accept;
            if (accept) begin
                col_d <= acc_col;
                col_q <= col_last ? '0 : acc_col + CW'(1);
                row_q <= col_last ? acc_row + RW'(1) : acc_row;
            end else if (vsync_rise) begin
                col_q <= '0;
                row_q <= '0;
            end
        end
    end

    // The RAM0 read register is column 3 of the middle row (p23); RAM1 takes
    // that old line one cycle later, after it has been read out of RAM0.
    sobel_line_buf #(.DEPTH(H_ACT), .AW(CW)) u_ram0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .wr_addr (acc_col),
        .wr_data (gray_data),
        .rd_en   (accept),
        .rd_addr (acc_col),
        .rd_data (p23)
    );

    sobel_line_buf #(.DEPTH(H_ACT), .AW(CW)) u_ram1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (acc_d),
        .wr_addr (col_d),
        .wr_data (p23),
        .rd_en   (accept),
        .rd_addr (acc_col),
        .rd_data (p13)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p11        <= '0;
            p12        <= '0;
            p21        <= '0;
            p22        <= '0;
            p31        <= '0;
            p32        <= '0;
            p33        <= '0;
            data_en    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            data_en    <= accept & (acc_row >= RW'(2)) & (acc_col >= CW'(2));
            frame_done <= last_px;
            if (accept) begin
                p11 <= p12;
                p12 <= p13;
                p21 <= p22;
                p22 <= p23;
                p31 <= p32;
                p32 <= p33;
                p33 <= gray_data;
            end
        end
    end

`ifdef SOBEL_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (last_px) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sobel_win_ctrl.sv
// Self-checking bench for sobel_win_ctrl on an 8x6 frame; windows are checked
// against an image-array model. Frame counter tests run with SOBEL_FRAME_CNT_EN.
module tb_sobel_win_ctrl;

    localparam int H = 8;
    localparam int V = 6;

    logic       clk = 1'b0;
    logic       rst_n, vsync, gray_valid;
    logic [7:0] gray_data;
    logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
    logic       data_en, frame_done, busy;
`ifdef SOBEL_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    always #5 clk = ~clk;

    sobel_win_ctrl #(.H_ACT(H), .V_ACT(V), .CW(10), .RW(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .gray_valid (gray_valid),
        .gray_data  (gray_data),
        .p11        (p11),
        .p12        (p12),
        .p13        (p13),
        .p21        (p21),
        .p22        (p22),
        .p23        (p23),
        .p31        (p31),
        .p32        (p32),
        .p33        (p33),
        .data_en    (data_en),
        .frame_done (frame_done),
        .busy       (busy)
`ifdef SOBEL_FRAME_CNT_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  img [V][H];
    logic [71:0] exp_q [$];
    logic [71:0] cap_q [$];
    int          done_cnt;
    int          done_wo_en;
    logic [7:0]  done_p33;

    function automatic logic [71:0] win_now();
        return {p11, p12, p13, p21, p22, p23, p31, p32, p33};
    endfunction

    always @(negedge clk) begin
        if (data_en) cap_q.push_back(win_now());
        if (frame_done) begin
            done_cnt++;
            done_p33 = p33;
            if (!data_en) done_wo_en++;
        end
    end

    task automatic cyc(input logic v, input logic vld, input logic [7:0] d);
        vsync      = v;
        gray_valid = vld;
        gray_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_vsync();
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic fill_img(input bit rnd);
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++)
                img[r][c] = rnd ? 8'($urandom) : 8'(r * 16 + c);
    endtask

    // Every interior pixel (r,c) yields the 3x3 neighbourhood ending at (r,c).
    task automatic build_exp();
        exp_q.delete();
        for (int r = 2; r < V; r++)
            for (int c = 2; c < H; c++)
                exp_q.push_back({img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                                 img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                                 img[r][c-2],   img[r][c-1],   img[r][c]});
    endtask

    task automatic clear_mon();
        cap_q.delete();
        done_cnt   = 0;
        done_wo_en = 0;
    endtask

    task automatic drive_pixels(input int n, input int gap_pct, input bit vs_first);
        for (int k = 0; k < n; k++) begin
            int g = 0;
            while (g < 8 && $urandom_range(99) < gap_pct) begin
                cyc(1'b0, 1'b0, 8'($urandom));
                g++;
            end
            cyc(vs_first && k == 0, 1'b1, img[k / H][k % H]);
        end
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) cyc(1'b0, 1'b1, 8'hA5);
        n_checks++;
        if (win_now() !== 72'h0 || data_en !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: win=%h en=%b done=%b busy=%b, want all zero",
                     win_now(), data_en, frame_done, busy);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 8'($urandom));
            n_checks++;
            if (data_en !== 1'b0 || busy !== 1'b0 || win_now() !== 72'h0) begin
                n_fail++;
                $display("FAIL idle_ignores: en=%b busy=%b win=%h, want 0 0 0", data_en, busy, win_now());
            end
        end
    endtask

    task automatic test_full_frame();
        clear_mon();
        fill_img(1'b0);
        build_exp();
        pulse_vsync();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_vsync: got %b want 1", busy);
        end
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                cyc(1'b0, 1'b1, img[r][c]);
                n_checks++;
                if (data_en !== (r >= 2 && c >= 2) || frame_done !== (r == V-1 && c == H-1)) begin
                    n_fail++;
                    $display("FAIL latency r%0d c%0d: en=%b done=%b want en=%b done=%b",
                             r, c, data_en, frame_done, (r >= 2 && c >= 2), (r == V-1 && c == H-1));
                end
                if (r == 2 && c == 2) begin
                    n_checks++;
                    if (win_now() !== 72'h00_01_02_10_11_12_20_21_22) begin
                        n_fail++;
                        $display("FAIL first_window: got %h want 000102101112202122", win_now());
                    end
                end
            end
        end
        n_checks++;
        if (p33 !== 8'h57 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL last_window: p33=%h busy=%b want 57 0", p33, busy);
        end
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        n_checks++;
        if (cap_q.size() !== 24 || done_cnt !== 1 || done_wo_en !== 0 || done_p33 !== 8'h57) begin
            n_fail++;
            $display("FAIL full_counts: en=%0d done=%0d lone_done=%0d p33=%h want 24 1 0 57",
                     cap_q.size(), done_cnt, done_wo_en, done_p33);
        end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL full_window %0d: got %h want %h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_gaps();
        clear_mon();
        fill_img(1'b0);
        build_exp();
        pulse_vsync();
        for (int k = 0; k < H * V; k++) begin
            logic [71:0] w;
            int g;
            w = win_now();
            g = 0;
            while (g < 6 && $urandom_range(99) < 50) begin
                cyc(1'b0, 1'b0, 8'($urandom));
                g++;
                n_checks++;
                if (win_now() !== w || data_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gap_hold k%0d: win=%h en=%b want %h 0", k, win_now(), data_en, w);
                end
            end
            cyc(1'b0, 1'b1, img[k / H][k % H]);
        end
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        n_checks++;
        if (cap_q.size() !== 24 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL gap_counts: en=%0d done=%0d want 24 1", cap_q.size(), done_cnt);
        end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL gap_window %0d: got %h want %h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_done_state();
        logic [71:0] w;
        clear_mon();
        w = win_now();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 8'($urandom));
            n_checks++;
            if (data_en !== 1'b0 || busy !== 1'b0 || win_now() !== w) begin
                n_fail++;
                $display("FAIL done_ignores %0d: en=%b busy=%b win=%h want 0 0 %h",
                         i, data_en, busy, win_now(), w);
            end
        end
        clear_mon();
        fill_img(1'b1);
        build_exp();
        pulse_vsync();
        drive_pixels(H * V, 25, 1'b0);
        n_checks++;
        if (cap_q.size() !== 24 || done_cnt !== 1 || done_wo_en !== 0) begin
            n_fail++;
            $display("FAIL after_done_counts: en=%0d done=%0d lone_done=%0d want 24 1 0",
                     cap_q.size(), done_cnt, done_wo_en);
        end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL after_done_window %0d: got %h want %h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_vsync_restart();
        clear_mon();
        fill_img(1'b1);
        pulse_vsync();
        drive_pixels(20, 0, 1'b0);
        n_checks++;
        if (cap_q.size() !== 2 || done_cnt !== 0) begin
            n_fail++;
            $display("FAIL partial_counts: en=%0d done=%0d want 2 0", cap_q.size(), done_cnt);
        end
        clear_mon();
        fill_img(1'b1);
        build_exp();
        drive_pixels(H * V, 0, 1'b1);
        n_checks++;
        if (cap_q.size() !== 24 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL restart_counts: en=%0d done=%0d want 24 1", cap_q.size(), done_cnt);
        end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL restart_window %0d: got %h want %h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        fill_img(1'b1);
        pulse_vsync();
        drive_pixels(20, 0, 1'b0);
        rst_n = 1'b0;
        cyc(1'b0, 1'b1, 8'h33);
        rst_n = 1'b1;
        n_checks++;
        if (win_now() !== 72'h0 || data_en !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: win=%h en=%b done=%b busy=%b want all zero",
                     win_now(), data_en, frame_done, busy);
        end
        clear_mon();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 8'($urandom));
            n_checks++;
            if (data_en !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_idle %0d: en=%b busy=%b want 0 0", i, data_en, busy);
            end
        end
        fill_img(1'b1);
        build_exp();
        pulse_vsync();
        drive_pixels(H * V, 30, 1'b0);
        n_checks++;
        if (cap_q.size() !== 24 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL midreset_counts: en=%0d done=%0d want 24 1", cap_q.size(), done_cnt);
        end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL midreset_window %0d: got %h want %h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

`ifdef SOBEL_FRAME_CNT_EN
    task automatic test_frame_cnt();
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        n_checks++;
        if (frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL frame_cnt_reset: got %0d want 0", frame_cnt);
        end
        for (int f = 0; f < 3; f++) begin
            fill_img(1'b1);
            pulse_vsync();
            drive_pixels(H * V, 20, 1'b0);
        end
        pulse_vsync();
        drive_pixels(10, 0, 1'b0);
        pulse_vsync();
        cyc(1'b0, 1'b0, 8'h00);
        n_checks++;
        if (frame_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL frame_cnt_three: got %0d want 3", frame_cnt);
        end
        force dut.frame_cnt = 16'hFFFF;
        cyc(1'b0, 1'b0, 8'h00);
        release dut.frame_cnt;
        pulse_vsync();
        drive_pixels(H * V, 0, 1'b0);
        n_checks++;
        if (frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL frame_cnt_wrap: got %0d want 0", frame_cnt);
        end
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        vsync      = 1'b0;
        gray_valid = 1'b0;
        gray_data  = 8'h00;
        clear_mon();
        test_reset();
        test_full_frame();
        test_gaps();
        test_done_state();
        test_vsync_restart();
        test_reset_mid();
`ifdef SOBEL_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
